norm_shift_ctrl: RTL and testbench

- Normalisation-side counterpart of the addend alignment shift counter in the MAF datapath.
- Takes the post-addition magnitude and the pre-normalisation exponent(s).
- Produces the left-shift count for the normaliser and the adjusted exponent(s).
- Honours the same precision modes (cont) as the alignment stage. Two-stage valid/ready pipeline between the adder and the normalising shifter.

---
 rtl/norm_shift_ctrl.sv | 247 ++++++++++++++++++++++++
 tb/tb_norm_shift_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/norm_shift_ctrl.sv
// -----------------------------------------------------------------------------
// norm_shift_ctrl
//
// Normalisation shift controller for the MAF datapath. It takes the
// post-addition magnitude and the pre-normalisation exponent(s), and produces
// the left-shift count for the normalising shifter together with the adjusted
// exponent(s). The shift is limited so that an exponent never drops below 1,
// which leaves subnormal results only partly normalised. The block is a
// two-stage valid/ready pipeline with a fully combinational ready chain.
//
// Precision modes (cont):
//   000 single wide lane, 001 dual lane, 010 mixed (single lane),
//   011..111 bypass (no shift, exponent passed through unchanged)
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-high reset
//   cont       in   precision mode
//   in_valid   in   input beat valid
//   in_ready   out  block accepts a beat this cycle
//   sum_mag    in   unsigned adder magnitude, SUM_W bits
//   e_in       in   signed exponent(s); dual mode packs {hi[6:0], lo[6:0]}
//   out_valid  out  result valid
//   out_ready  in   downstream accepts the result
//   sh_num     out  left-shift count; dual {hi, lo}, otherwise {7'b0, cnt}
//   e_out      out  adjusted exponent(s), same packing as e_in
//   zero       out  all-zero lane flags; bit1 hi lane (dual only), bit0 lo/single
//   cont_out   out  mode carried alongside the result
// -----------------------------------------------------------------------------
module norm_shift_ctrl #(
    parameter int SUM_W = 108,
    parameter int EXP_W = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         cont,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SUM_W-1:0]   sum_mag,
    input  logic [EXP_W-1:0]   e_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [13:0]        sh_num,
    output logic [EXP_W-1:0]   e_out,
    output logic [1:0]         zero,
    output logic [2:0]         cont_out
);

    localparam int HALF_W  = SUM_W / 2;
    localparam int LANE_EW = EXP_W / 2;
    localparam int CNT_W   = 7;

    localparam logic [2:0] MODE_SINGLE = 3'b000;
    localparam logic [2:0] MODE_DUAL   = 3'b001;
    localparam logic [2:0] MODE_MIXED  = 3'b010;

    // -------------------------------------------------------------------------
    // Leading-zero counters. Scanning upward, the last set bit seen is the
    // most significant one, so its distance from the top wins.
    // -------------------------------------------------------------------------
    function automatic logic [CNT_W-1:0] lz_wide(input logic [SUM_W-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < SUM_W; i++) begin
            if (v[i]) n = CNT_W'(SUM_W - 1 - i);
        end
        return n;
    endfunction

    function automatic logic [CNT_W-1:0] lz_half(input logic [HALF_W-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < HALF_W; i++) begin
            if (v[i]) n = CNT_W'(HALF_W - 1 - i);
        end
        return n;
    endfunction

    // -------------------------------------------------------------------------
    // Subnormal clamp: sh = min(lz, E-1) for E >= 1, else 0. The limit is
    // formed one bit wider than the exponent so E-1 of the largest positive
    // exponent cannot wrap. Since sh <= E-1, E - sh stays in range and the
    // final subtraction is exact at exponent width.
    // -------------------------------------------------------------------------
    function automatic void clamp_wide(
        input  logic [CNT_W-1:0] lz,
        input  logic [EXP_W-1:0] ev,
        output logic [CNT_W-1:0] sh,
        output logic [EXP_W-1:0] e_res
    );
        logic             pos;
        logic [EXP_W:0]   limit;
        logic [EXP_W:0]   lz_x;
        pos   = !ev[EXP_W-1] && (ev != '0);
        limit = pos ? ({1'b0, ev} - (EXP_W+1)'(1)) : '0;
        lz_x  = (EXP_W+1)'(lz);
        sh    = (lz_x < limit) ? lz : limit[CNT_W-1:0];
        e_res = ev - EXP_W'(sh);
    endfunction

    function automatic void clamp_lane(
        input  logic [CNT_W-1:0]   lz,
        input  logic [LANE_EW-1:0] ev,
        output logic [CNT_W-1:0]   sh,
        output logic [LANE_EW-1:0] e_res
    );
        logic               pos;
        logic [LANE_EW:0]   limit;
        logic [LANE_EW:0]   lz_x;
        pos   = !ev[LANE_EW-1] && (ev != '0);
        limit = pos ? ({1'b0, ev} - (LANE_EW+1)'(1)) : '0;
        lz_x  = (LANE_EW+1)'(lz);
        sh    = (lz_x < limit) ? lz : limit[CNT_W-1:0];
        e_res = ev - LANE_EW'(sh);
    endfunction

    // -------------------------------------------------------------------------
    // Handshake
    // -------------------------------------------------------------------------
    logic s1_valid;
    logic s2_valid;
    logic s2_ready;

    assign s2_ready  = !s2_valid || out_ready;
    assign in_ready  = !s1_valid || s2_ready;
    assign out_valid = s2_valid;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (in_ready) s1_valid <= in_valid;
            if (s2_ready) s2_valid <= s1_valid;
        end
    end

    // -------------------------------------------------------------------------
    // Stage 1: leading-zero count(s) and lane zero detection
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0] lz_hi_d, lz_lo_d;
    logic [1:0]       zero_d;

    // NOTE: every output of a combinational block is given a default first, so
    // no path through the block leaves a value held and no latch is inferred.
    always_comb begin
        lz_hi_d = '0;
        lz_lo_d = '0;
        zero_d  = '0;
        if (cont == MODE_DUAL) begin
            lz_hi_d = lz_half(sum_mag[SUM_W-1:HALF_W]);
            lz_lo_d = lz_half(sum_mag[HALF_W-1:0]);
            zero_d  = {sum_mag[SUM_W-1:HALF_W] == '0, sum_mag[HALF_W-1:0] == '0};
        end else begin
            lz_lo_d = lz_wide(sum_mag);
            zero_d  = {1'b0, sum_mag == '0};
        end
    end

    logic [2:0]       s1_cont;
    logic [EXP_W-1:0] s1_e;
    logic [CNT_W-1:0] s1_lz_hi, s1_lz_lo;
    logic [1:0]       s1_zero;

    // NOTE: pipeline payload registers carry no reset; they are only observed
    // when qualified by s1_valid, which is reset.
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            s1_cont  <= cont;
            s1_e     <= e_in;
            s1_lz_hi <= lz_hi_d;
            s1_lz_lo <= lz_lo_d;
            s1_zero  <= zero_d;
        end
    end

    // -------------------------------------------------------------------------
    // Stage 2: clamp, exponent adjust, lane packing
    // -------------------------------------------------------------------------
    logic [13:0]        sh_d;
    logic [EXP_W-1:0]   e_d;
    logic [1:0]         zero_out_d;
    logic [CNT_W-1:0]   sh_wide, sh_hi, sh_lo;
    logic [EXP_W-1:0]   e_wide;
    logic [LANE_EW-1:0] e_hi, e_lo;

    always_comb begin
        sh_d       = '0;
        e_d        = '0;
        zero_out_d = '0;
        sh_wide    = '0;
        sh_hi      = '0;
        sh_lo      = '0;
        e_wide     = '0;
        e_hi       = '0;
        e_lo       = '0;
        case (s1_cont)
            MODE_SINGLE, MODE_MIXED: begin
                clamp_wide(s1_lz_lo, s1_e, sh_wide, e_wide);
                if (s1_zero[0]) begin
                    zero_out_d = 2'b01;
                end else begin
                    sh_d = {7'b0, sh_wide};
                    e_d  = e_wide;
                end
            end
            MODE_DUAL: begin
                clamp_lane(s1_lz_hi, s1_e[EXP_W-1:LANE_EW], sh_hi, e_hi);
                clamp_lane(s1_lz_lo, s1_e[LANE_EW-1:0], sh_lo, e_lo);
                // An all-zero lane reports no shift and a zero exponent.
                if (s1_zero[1]) begin
                    sh_hi = '0;
                    e_hi  = '0;
                end
                if (s1_zero[0]) begin
                    sh_lo = '0;
                    e_lo  = '0;
                end
                sh_d       = {sh_hi, sh_lo};
                e_d        = {e_hi, e_lo};
                zero_out_d = s1_zero;
            end
            default: begin
                e_d = s1_e;
            end
        endcase
    end

    // Output registers only load on a stage transfer, so they hold while the
    // downstream stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_num   <= '0;
            e_out    <= '0;
            zero     <= '0;
            cont_out <= '0;
        end else if (s1_valid && s2_ready) begin
            sh_num   <= sh_d;
            e_out    <= e_d;
            zero     <= zero_out_d;
            cont_out <= s1_cont;
        end
    end

endmodule

// File: tb/tb_norm_shift_ctrl.sv
module tb_norm_shift_ctrl;

    logic         clk;
    logic         rst;
    logic [2:0]   cont;
    logic         in_valid;
    logic         in_ready;
    logic [107:0] sum_mag;
    logic [13:0]  e_in;
    logic         out_valid;
    logic         out_ready;
    logic [13:0]  sh_num;
    logic [13:0]  e_out;
    logic [1:0]   zero;
    logic [2:0]   cont_out;

    norm_shift_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .cont      (cont),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum_mag   (sum_mag),
        .e_in      (e_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sh_num    (sh_num),
        .e_out     (e_out),
        .zero      (zero),
        .cont_out  (cont_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [13:0] sh;
        logic [13:0] eo;
        logic [1:0]  z;
        logic [2:0]  c;
    } res_t;

    typedef struct {
        logic [2:0]   c;
        logic [107:0] s;
        logic [13:0]  e;
        res_t         r;
    } vec_t;

    int   n_checks = 0;
    int   n_errors = 0;
    res_t exp_q[$];
    logic held_valid = 1'b0;
    res_t held;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, expv);
        end
    endtask

    // Reference: count leading zeros by shifting, then apply the exponent clamp
    // with plain integer arithmetic.
    function automatic void lane_ref(input logic [107:0] v, input int w, input int ev,
                                     output int sh, output int eo, output bit z);
        int n;
        int limit;
        z = (v == '0);
        if (z) begin
            sh = 0;
            eo = 0;
        end else begin
            n = 0;
            while (!v[w-1]) begin
                v = v << 1;
                n++;
            end
            limit = (ev >= 1) ? ev - 1 : 0;
            sh = (n < limit) ? n : limit;
            eo = ev - sh;
        end
    endfunction

    function automatic res_t model(input logic [2:0] c, input logic [107:0] s, input logic [13:0] e);
        res_t r;
        int sh_h, eo_h, sh_l, eo_l;
        bit z_h, z_l;
        r = '0;
        r.c = c;
        if (c == 3'd0 || c == 3'd2) begin
            lane_ref(s, 108, int'($signed(e)), sh_l, eo_l, z_l);
            r.sh = 14'(sh_l);
            r.eo = 14'(eo_l);
            r.z  = {1'b0, z_l};
        end else if (c == 3'd1) begin
            lane_ref({54'b0, s[107:54]}, 54, int'($signed(e[13:7])), sh_h, eo_h, z_h);
            lane_ref({54'b0, s[53:0]}, 54, int'($signed(e[6:0])), sh_l, eo_l, z_l);
            r.sh = {7'(sh_h), 7'(sh_l)};
            r.eo = {7'(eo_h), 7'(eo_l)};
            r.z  = {z_h, z_l};
        end else begin
            r.eo = e;
        end
        return r;
    endfunction

    // One clock of stimulus; checks a consumed result against the scoreboard
    // and checks that a stalled result did not move.
    task automatic cycle(input logic v, input logic [2:0] c, input logic [107:0] s,
                         input logic [13:0] e, input logic rdy, input res_t expv,
                         output logic acc);
        res_t got;
        @(posedge clk);
        #1;
        in_valid  = v;
        cont      = c;
        sum_mag   = s;
        e_in      = e;
        out_ready = rdy;
        #1;
        got = {sh_num, e_out, zero, cont_out};
        if (held_valid)
            check("hold_stable", 64'({out_valid, got}), 64'({1'b1, held}));
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0)
                check("unexpected_out", 64'(out_valid), 64'(0));
            else
                check("result", 64'(got), 64'(exp_q.pop_front()));
        end
        held_valid = out_valid && !out_ready;
        held = got;
        acc = v && in_ready;
        if (acc) exp_q.push_back(expv);
    endtask

    task automatic idle(input logic rdy);
        logic acc;
        cycle(1'b0, 3'd0, '0, '0, rdy, '0, acc);
    endtask

    task automatic drain();
        for (int i = 0; i < 64 && exp_q.size() > 0; i++) idle(1'b1);
        check("drain_empty", 64'(exp_q.size()), 64'(0));
    endtask

    task automatic latency_run(input vec_t t);
        logic acc;
        cycle(1'b1, t.c, t.s, t.e, 1'b1, t.r, acc);
        check("lat_accept", 64'(acc), 64'(1));
        idle(1'b1);
        check("lat_not_yet", 64'(out_valid), 64'(0));
        idle(1'b1);
        check("lat_valid", 64'(out_valid), 64'(1));
        check("lat_consumed", 64'(exp_q.size()), 64'(0));
    endtask

    function automatic logic [107:0] rand_mag(input int width);
        logic [127:0] r;
        int k;
        r = {$urandom, $urandom, $urandom, $urandom};
        k = $urandom_range(0, width);
        r = r >> (128 - width + k);
        return r[107:0];
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    vec_t tbl[13];

    initial begin
        logic acc;
        logic saw_block;
        int   idx;
        logic [2:0]   rc;
        logic [107:0] rs;
        logic [13:0]  re;
        int           k;

        tbl[0]  = '{3'd0, 108'd1 << 100, 14'd50,    '{14'd7,   14'd43,    2'b00, 3'd0}};
        tbl[1]  = '{3'd0, 108'd1 << 10,  14'd20,    '{14'd19,  14'd1,     2'b00, 3'd0}};
        tbl[2]  = '{3'd0, 108'd1 << 10,  14'h3FFD,  '{14'd0,   14'h3FFD,  2'b00, 3'd0}};
        tbl[3]  = '{3'd1, 108'd1 << 104, 14'd1320,  '{14'd384, 14'd896,   2'b01, 3'd1}};
        tbl[4]  = '{3'd5, 108'h123,      14'h1234,  '{14'd0,   14'h1234,  2'b00, 3'd5}};
        tbl[5]  = '{3'd0, 108'd0,        14'd50,    '{14'd0,   14'd0,     2'b01, 3'd0}};
        tbl[6]  = '{3'd2, 108'd1 << 107, 14'd5,     '{14'd0,   14'd5,     2'b00, 3'd2}};
        tbl[7]  = '{3'd0, 108'd1,        14'd200,   '{14'd107, 14'd93,    2'b00, 3'd0}};
        tbl[8]  = '{3'd1, 108'd1 << 53,  14'h3D81,  '{14'd0,   14'd1,     2'b10, 3'd1}};
        tbl[9]  = '{3'd1, (108'd1 << 54) | 108'd1, 14'h1F80, '{14'd6784, 14'd1280, 2'b00, 3'd1}};
        tbl[10] = '{3'd0, 108'd1 << 50,  14'd1,     '{14'd0,   14'd1,     2'b00, 3'd0}};
        tbl[11] = '{3'd7, 108'd0,        14'h3FFF,  '{14'd0,   14'h3FFF,  2'b00, 3'd7}};
        tbl[12] = '{3'd2, 108'd1,        14'h2000,  '{14'd0,   14'h2000,  2'b00, 3'd2}};

        rst = 1'b1;
        in_valid = 1'b0;
        cont = '0;
        sum_mag = '0;
        e_in = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", 64'({out_valid, in_ready, sh_num, e_out, zero, cont_out}),
              64'({1'b0, 1'b1, 14'd0, 14'd0, 2'b00, 3'd0}));
        rst = 1'b0;

        // Two-cycle latency on the first plan vector.
        latency_run(tbl[0]);

        // Whole table back-to-back at full throughput.
        for (int i = 0; i < 13; i++) begin
            cycle(1'b1, tbl[i].c, tbl[i].s, tbl[i].e, 1'b1, tbl[i].r, acc);
            check("tbl_accept", 64'(acc), 64'(1));
        end
        drain();

        // Stall: four beats offered while the output is held off for a while.
        idx = 1;
        saw_block = 1'b0;
        for (int cyc = 0; cyc < 40 && idx <= 4; cyc++) begin
            cycle(1'b1, tbl[idx].c, tbl[idx].s, tbl[idx].e, (cyc == 0 || cyc > 4), tbl[idx].r, acc);
            if (!acc) saw_block = 1'b1;
            if (acc) idx++;
        end
        check("stall_all_accepted", 64'(idx), 64'(5));
        check("stall_in_ready_dropped", 64'(saw_block), 64'(1));
        drain();

        // Reset with two beats in flight.
        cycle(1'b1, tbl[0].c, tbl[0].s, tbl[0].e, 1'b0, tbl[0].r, acc);
        cycle(1'b1, tbl[1].c, tbl[1].s, tbl[1].e, 1'b0, tbl[1].r, acc);
        idle(1'b0);
        check("pre_rst_full", 64'({out_valid, in_ready}), 64'({1'b1, 1'b0}));
        #2;
        rst = 1'b1;
        #1;
        check("rst_flush", 64'({out_valid, in_ready}), 64'({1'b0, 1'b1}));
        exp_q.delete();
        held_valid = 1'b0;
        idle(1'b1);
        idle(1'b1);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            idle(1'b1);
            check("no_stale", 64'(out_valid), 64'(0));
        end
        latency_run(tbl[3]);

        // Random traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            k = $urandom_range(0, 9);
            rc = (k < 3) ? 3'd0 : (k < 6) ? 3'd1 : (k < 8) ? 3'd2 : 3'($urandom_range(3, 7));
            if (rc == 3'd1) rs = {rand_mag(54)[53:0], rand_mag(54)[53:0]};
            else            rs = rand_mag(108);
            if ($urandom_range(0, 1) == 0) re = 14'($urandom);
            else if (rc == 3'd1) re = {7'($urandom_range(0, 63)), 7'($urandom_range(0, 63))};
            else re = 14'($urandom_range(0, 130));
            cycle($urandom_range(0, 9) < 7, rc, rs, re, $urandom_range(0, 9) < 7,
                  model(rc, rs, re), acc);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
